// File: rtl/irda_sip_gen_param_pkg.sv
// Shared types and default phase lengths for the parametrised SIP generator.
package irda_sip_gen_param_pkg;

    typedef enum logic [1:0] {
        SipIdle = 2'd0,
        SipHigh = 2'd1,
        SipLow  = 2'd2,
        SipEnd  = 2'd3
    } sip_state_e;

    localparam int unsigned DefHighCyc = 64;
    localparam int unsigned DefLowCyc  = 284;
    localparam int unsigned DefEndCyc  = 71;

endpackage

// File: rtl/irda_sip_gen_param_period_timer.sv
// Auto-SIP period counter: counts qualified idle cycles and emits a one-cycle
// tick when the count reaches period_i-1. A zero period never ticks.
module irda_sip_gen_param_period_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                wb_rst_i,
    input  logic                run_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                qual;

    always_comb begin
        qual   = run_i & (period_i != '0);
        tick_o = qual & (cnt_q == (period_i - PERIOD_W'(1)));
        // A tick starts a SIP, so the count restarts from zero either way.
        cnt_d  = (qual & ~tick_o) ? (cnt_q + PERIOD_W'(1)) : '0;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/irda_sip_gen_param.sv
// Parametrised SIP generator with one-deep request queue, abort and auto-SIP.
// Optional build macro IRDA_SIP_STATS_EN adds sip_cnt_o and drop_o.
module irda_sip_gen_param
    import irda_sip_gen_param_pkg::*;
#(
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned HIGH_CYC = DefHighCyc,
    parameter int unsigned LOW_CYC  = DefLowCyc,
    parameter int unsigned END_CYC  = DefEndCyc,
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                wb_rst_i,
    input  logic                fast_enable,
    input  logic                sip_req_i,
    input  logic                abort_i,
    input  logic                auto_en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                sip_gen_o,
    output logic                sip_end_o,
    output logic                busy_o,
    output logic                pend_o
`ifdef IRDA_SIP_STATS_EN
    ,
    output logic [15:0]         sip_cnt_o,
    output logic                drop_o
`endif
);

    localparam logic [CNT_W-1:0] HighLoad = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LowLoad  = CNT_W'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0] EndLoad  = CNT_W'(END_CYC - 1);

    sip_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             pend_q, pend_d;
    logic             sip_gen_q, sip_gen_d;
    logic             sip_end_q, sip_end_d;
    logic             busy_q, busy_d;

    logic             rise, req, kill, cnt_zero, auto_tick, timer_run;
    logic [CNT_W-1:0] cnt_dec;

    assign timer_run = fast_enable & auto_en_i & (state_q == SipIdle) & ~pend_q;

    irda_sip_gen_param_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_period_timer (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .run_i    (timer_run),
        .period_i (period_i),
        .tick_o   (auto_tick)
    );

    always_comb begin
        rise     = sip_req_i & ~prev_q;
        req      = rise | auto_tick;
        kill     = abort_i | ~fast_enable;
        cnt_zero = (cnt_q == '0);
        cnt_dec  = cnt_q - CNT_W'(1);

        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        if (kill) begin
            state_d = SipIdle;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                SipIdle: begin
                    if (req) begin
                        state_d = SipHigh;
                        cnt_d   = HighLoad;
                    end
                end
                SipHigh: begin
                    if (cnt_zero) begin
                        state_d = SipLow;
                        cnt_d   = LowLoad;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                SipLow: begin
                    if (cnt_zero) begin
                        state_d = SipEnd;
                        cnt_d   = EndLoad;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                SipEnd: begin
                    if (cnt_zero) begin
                        // A request landing on the last END cycle still yields
                        // exactly one follow-on SIP, merged with any pending one.
                        if (pend_q | req) begin
                            state_d = SipHigh;
                            cnt_d   = HighLoad;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = SipIdle;
                        end
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                default: begin
                    state_d = SipIdle;
                    cnt_d   = '0;
                end
            endcase

            if (req && (state_q != SipIdle) && !((state_q == SipEnd) && cnt_zero)) begin
                pend_d = 1'b1;
            end
        end

        sip_gen_d = (state_d == SipHigh);
        sip_end_d = (state_d == SipEnd);
        busy_d    = (state_d != SipIdle);
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= SipIdle;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            pend_q    <= 1'b0;
            sip_gen_q <= 1'b0;
            sip_end_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= sip_req_i;
            pend_q    <= pend_d;
            sip_gen_q <= sip_gen_d;
            sip_end_q <= sip_end_d;
            busy_q    <= busy_d;
        end
    end

    assign sip_gen_o = sip_gen_q;
    assign sip_end_o = sip_end_q;
    assign busy_o    = busy_q;
    assign pend_o    = pend_q;

`ifdef IRDA_SIP_STATS_EN
    logic [15:0] sip_cnt_q, sip_cnt_d;
    logic        drop_q, drop_d;

    always_comb begin
        sip_cnt_d = sip_cnt_q;
        if (!kill && (state_q == SipEnd) && cnt_zero) begin
            sip_cnt_d = sip_cnt_q + 16'd1;
        end
        drop_d = ~kill & req & pend_q & (state_q != SipIdle);
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sip_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            sip_cnt_q <= sip_cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign sip_cnt_o = sip_cnt_q;
    assign drop_o    = drop_q;
`endif

endmodule

// File: tb/tb_irda_sip_gen_param.sv
// Self-checking bench: default and 8/16/4 instances run in lockstep with a
// timeline model (SIP start time + elapsed cycles) under directed and random stimulus.
module tb_irda_sip_gen_param;

    localparam int unsigned PW = 24;
    localparam int unsigned MH [2] = '{64, 8};
    localparam int unsigned ML [2] = '{284, 16};
    localparam int unsigned ME [2] = '{71, 4};

    logic          clk = 1'b0;
    logic          wb_rst_i, fast_enable, sip_req_i, abort_i, auto_en_i;
    logic [PW-1:0] period_i;
    logic          gen0, end0, busy0, pend0;
    logic          gen1, end1, busy1, pend1;
`ifdef IRDA_SIP_STATS_EN
    logic [15:0]   cnt0, cnt1;
    logic          drop0, drop1;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    irda_sip_gen_param #(
        .CNT_W    (10),
        .HIGH_CYC (64),
        .LOW_CYC  (284),
        .END_CYC  (71),
        .PERIOD_W (PW)
    ) dut0 (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .fast_enable (fast_enable),
        .sip_req_i   (sip_req_i),
        .abort_i     (abort_i),
        .auto_en_i   (auto_en_i),
        .period_i    (period_i),
        .sip_gen_o   (gen0),
        .sip_end_o   (end0),
        .busy_o      (busy0),
        .pend_o      (pend0)
`ifdef IRDA_SIP_STATS_EN
        ,
        .sip_cnt_o   (cnt0),
        .drop_o      (drop0)
`endif
    );

    irda_sip_gen_param #(
        .CNT_W    (5),
        .HIGH_CYC (8),
        .LOW_CYC  (16),
        .END_CYC  (4),
        .PERIOD_W (PW)
    ) dut1 (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .fast_enable (fast_enable),
        .sip_req_i   (sip_req_i),
        .abort_i     (abort_i),
        .auto_en_i   (auto_en_i),
        .period_i    (period_i),
        .sip_gen_o   (gen1),
        .sip_end_o   (end1),
        .busy_o      (busy1),
        .pend_o      (pend1)
`ifdef IRDA_SIP_STATS_EN
        ,
        .sip_cnt_o   (cnt1),
        .drop_o      (drop1)
`endif
    );

    // Model: a SIP is "active" with elapsed cycle index m_el; outputs are
    // derived from where m_el falls in the H/L/E timeline.
    bit          m_act  [2];
    int unsigned m_el   [2];
    bit          m_pend [2];
    int unsigned m_idle [2];
    bit          m_drop [2];
    int unsigned m_done [2];
    bit          m_prev;

    always @(posedge clk) begin
        bit rise, qual, tick, r;
        if (wb_rst_i) begin
            m_prev = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_el[i] = 0; m_pend[i] = 0;
                m_idle[i] = 0; m_drop[i] = 0; m_done[i] = 0;
            end
        end else begin
            rise = sip_req_i && !m_prev;
            for (int i = 0; i < 2; i++) begin
                qual = fast_enable && auto_en_i && (period_i != 0) && !m_act[i] && !m_pend[i];
                tick = qual && (m_idle[i] == period_i - 1);
                m_idle[i] = (qual && !tick) ? m_idle[i] + 1 : 0;
                r = (rise && fast_enable) || tick;
                m_drop[i] = 0;
                if (abort_i || !fast_enable) begin
                    m_act[i]  = 0;
                    m_pend[i] = 0;
                end else if (!m_act[i]) begin
                    if (r) begin
                        m_act[i] = 1;
                        m_el[i]  = 0;
                    end
                end else begin
                    if (r && m_pend[i]) m_drop[i] = 1;
                    if (m_el[i] == MH[i] + ML[i] + ME[i] - 1) begin
                        m_done[i]++;
                        if (m_pend[i] || r) begin
                            m_el[i]   = 0;
                            m_pend[i] = 0;
                        end else begin
                            m_act[i] = 0;
                        end
                    end else begin
                        m_el[i]++;
                        if (r) m_pend[i] = 1;
                    end
                end
            end
            m_prev = sip_req_i;
        end
    end

    function automatic logic [3:0] exp_of(int i);
        logic g, e;
        g = m_act[i] && (m_el[i] < MH[i]);
        e = m_act[i] && (m_el[i] >= MH[i] + ML[i]);
        return {g, e, m_act[i], m_pend[i]};
    endfunction

    function automatic logic [7:0] exp_vec();
        return {exp_of(0), exp_of(1)};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {gen0, end0, busy0, pend0, gen1, end1, busy1, pend1};
    endfunction

    task automatic test_reset();
        wb_rst_i = 1; fast_enable = 0; sip_req_i = 0; abort_i = 0;
        auto_en_i = 0; period_i = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", obs_vec(), 8'h00);
        end
`ifdef IRDA_SIP_STATS_EN
        n_cmp++;
        if ({cnt0, cnt1, drop0, drop1} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_stats: got %h/%h/%b%b want 0", cnt0, cnt1, drop0, drop1);
        end
`endif
        wb_rst_i = 0;
        @(negedge clk);
    endtask

    task automatic test_single_sip();
        int unsigned nb0 = 0, nb1 = 0, ng0 = 0, ne0 = 0;
        fast_enable = 1;
        sip_req_i   = 1;
        for (int c = 0; c < 430; c++) begin
            if (c == 3) sip_req_i = 0;
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single_sip cyc %0d: got %b want %b", c, obs_vec(), exp_vec());
            end
            nb0 += busy0; nb1 += busy1; ng0 += gen0; ne0 += end0;
        end
        n_cmp++;
        if (nb0 != 419) begin
            n_err++; $display("FAIL single_busy_len0: got %0d want 419", nb0);
        end
        n_cmp++;
        if (nb1 != 28) begin
            n_err++; $display("FAIL single_busy_len1: got %0d want 28", nb1);
        end
        n_cmp++;
        if (ng0 != 64 || ne0 != 71) begin
            n_err++; $display("FAIL single_phase_len: got gen %0d end %0d want 64 71", ng0, ne0);
        end
    endtask

    task automatic test_queued();
        int unsigned nb0 = 0;
        sip_req_i = 1;
        for (int c = 0; c < 900; c++) begin
            if (c == 5) sip_req_i = 0;
            if (c == 100) sip_req_i = 1;
            if (c == 110) sip_req_i = 0;
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL queued cyc %0d: got %b want %b", c, obs_vec(), exp_vec());
            end
            if (c == 100) begin
                n_cmp++;
                if (pend0 !== 1'b1) begin
                    n_err++; $display("FAIL queued_pend: got %b want 1", pend0);
                end
            end
            nb0 += busy0;
        end
        n_cmp++;
        if (nb0 != 838) begin
            n_err++; $display("FAIL queued_two_sips: got busy %0d want 838", nb0);
        end
    endtask

    task automatic test_abort();
        sip_req_i = 1;
        for (int c = 0; c < 500; c++) begin
            if (c == 5) sip_req_i = 0;
            if (c == 10) sip_req_i = 1;
            if (c == 15) sip_req_i = 0;
            abort_i = (c == 30);
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL abort cyc %0d: got %b want %b", c, obs_vec(), exp_vec());
            end
            if (c == 29) begin
                n_cmp++;
                if ({gen0, pend0} !== 2'b11) begin
                    n_err++; $display("FAIL abort_pre: got %b want 11", {gen0, pend0});
                end
            end
            if (c == 30) begin
                n_cmp++;
                if ({gen0, end0, busy0, pend0} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL abort_post: got %b want 0000", {gen0, end0, busy0, pend0});
                end
            end
        end
        abort_i = 0;
    endtask

    task automatic test_fast_enable();
        int unsigned nb = 0;
        sip_req_i = 1;
        for (int c = 0; c < 700; c++) begin
            if (c == 5) sip_req_i = 0;
            if (c == 100) fast_enable = 0;
            if (c == 120) sip_req_i = 1;
            if (c == 130) sip_req_i = 0;
            if (c == 140) sip_req_i = 1;
            if (c == 200) fast_enable = 1;
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL fast_enable cyc %0d: got %b want %b", c, obs_vec(), exp_vec());
            end
            if (c >= 100) nb += busy0 + busy1;
        end
        n_cmp++;
        if (nb != 0) begin
            n_err++; $display("FAIL fe_no_sip: got busy %0d want 0", nb);
        end
        sip_req_i = 0;
    endtask

    task automatic test_auto();
        int unsigned starts = 0;
        logic        b_prev;
        abort_i = 1;
        @(negedge clk);
        abort_i = 0; auto_en_i = 1; period_i = PW'(1000);
        b_prev = busy0;
        for (int c = 0; c < 4700; c++) begin
            if (c == 3200) begin
                period_i = '0;
                n_cmp++;
                if (starts != 2) begin
                    n_err++; $display("FAIL auto_starts: got %0d want 2", starts);
                end
                starts = 0;
            end
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL auto cyc %0d: got %b want %b", c, obs_vec(), exp_vec());
            end
            if (busy0 && !b_prev) starts++;
            b_prev = busy0;
        end
        n_cmp++;
        if (starts != 0) begin
            n_err++; $display("FAIL auto_period0: got %0d starts want 0", starts);
        end
        auto_en_i = 0;
    endtask

    task automatic test_reset_mid();
        sip_req_i = 1;
        for (int c = 0; c < 60; c++) begin
            if (c == 3) sip_req_i = 0;
            @(negedge clk);
        end
        wb_rst_i = 1;
        #1;
        n_cmp++;
        if (obs_vec() !== 8'h00) begin
            n_err++; $display("FAIL reset_async: got %b want %b", obs_vec(), 8'h00);
        end
        @(negedge clk);
        wb_rst_i = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(19, 0) == 0) sip_req_i = ~sip_req_i;
            abort_i = ($urandom_range(399, 0) == 0);
            if ($urandom_range(799, 0) == 0) fast_enable = ~fast_enable;
            if ($urandom_range(999, 0) == 0) auto_en_i = ~auto_en_i;
            if ($urandom_range(499, 0) == 0) period_i = PW'($urandom_range(300, 0));
            if (c == 0) begin
                auto_en_i = 1; period_i = PW'(1);
            end
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b want %b", c, obs_vec(), exp_vec());
            end
`ifdef IRDA_SIP_STATS_EN
            n_cmp++;
            if ({cnt0, cnt1, drop0, drop1} !==
                {16'(m_done[0]), 16'(m_done[1]), m_drop[0], m_drop[1]}) begin
                n_err++;
                $display("FAIL random_stats cyc %0d: got %h %h %b%b want %h %h %b%b", c,
                         cnt0, cnt1, drop0, drop1, 16'(m_done[0]), 16'(m_done[1]),
                         m_drop[0], m_drop[1]);
            end
`endif
        end
        abort_i = 0;
    endtask

    initial begin
        test_reset();
        test_single_sip();
        test_queued();
        test_abort();
        test_fast_enable();
        test_auto();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
